// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one word-wide RAM port between four cache requesters:
// 0 = icache0, 1 = dcache0, 2 = icache1, 3 = dcache1.
// The arbiter picks requesters in round-robin order and keeps the grant until
// the whole transaction is done. A transaction is one word, or a two-word
// block when burst=1. The arbiter drives the RAM handshake and returns one
// acknowledge pulse for each completed word.
//
// Ports
//   CLK, RST          clock (rising edge); reset (synchronous, active-high)
//   req[3:0]          request, one bit per requester
//   wen[3:0]          1 = write, 0 = read; latched at grant
//   burst[3:0]        1 = two-word block; latched at grant
//   addr[3:0]         word-aligned start address per requester; latched at grant
//   wdata[3:0]        store data per requester; sampled live
//   ack[3:0]          one-cycle pulse per completed word, granted index only
//   rdata             load data; valid in the ack cycle, 0 otherwise
//   busy              a transaction is in progress
//   gnt_id            index currently (or most recently) granted
//   ram_ren/ram_wen   RAM read/write enables; never both high
//   ram_addr          RAM address
//   ram_wdata         RAM write data
//   ram_rdata         RAM read data
//   ram_rdy           RAM completes the current access this cycle
// ----------------------------------------------------------------------------
module ram_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [3:0]             req,
   input  logic [3:0]             wen,
   input  logic [3:0]             burst,
   input  logic [3:0][ADDR_W-1:0] addr,
   input  logic [3:0][DATA_W-1:0] wdata,
   output logic [3:0]             ack,
   output logic [DATA_W-1:0]      rdata,
   output logic                   busy,
   output logic [1:0]             gnt_id,
   output logic                   ram_ren,
   output logic                   ram_wen,
   output logic [ADDR_W-1:0]      ram_addr,
   output logic [DATA_W-1:0]      ram_wdata,
   input  logic [DATA_W-1:0]      ram_rdata,
   input  logic                   ram_rdy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WORD1 = 2'd1,
      WORD2 = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_last;
   logic [1:0]        r_gnt;
   logic              r_wen;
   logic              r_burst;
   logic [ADDR_W-1:0] r_addr;

   logic              w_any;
   logic [1:0]        w_winner;
   logic              w_done;

   // Round-robin search. Offsets are visited from the farthest (4, which is
   // r_last itself) down to the nearest (1). A later match overwrites an
   // earlier one, so the requester closest after r_last wins.
   always_comb begin
      // NOTE: every signal gets a default before any branch. A combinational
      // output that is left unassigned on some path becomes a latch.
      w_any    = |req;
      w_winner = r_last;
      for (int i = 4; i >= 1; i--) begin
         if (req[r_last + 2'(i)]) begin
            w_winner = r_last + 2'(i);
         end
      end
   end

   // Next-state logic. A transaction ends on the ready of its final word.
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next = WORD1;
            end
         end
         WORD1: begin
            if (ram_rdy) begin
               w_next = r_burst ? WORD2 : IDLE;
               w_done = !r_burst;
            end
         end
         WORD2: begin
            if (ram_rdy) begin
               w_next = IDLE;
               w_done = 1'b1;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // RAM handshake and requester outputs, decoded from the current state.
   // The ack is suppressed while RST is high, so a word aborted by reset
   // is never acknowledged.
   always_comb begin
      ack       = '0;
      rdata     = '0;
      busy      = 1'b0;
      gnt_id    = r_gnt;
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (r_state == WORD1 || r_state == WORD2) begin
         busy      = 1'b1;
         ram_ren   = !r_wen;
         ram_wen   = r_wen;
         // The second word's address wraps at 2^ADDR_W because of the
         // ADDR_W-bit add.
         ram_addr  = (r_state == WORD2) ? (r_addr + ADDR_W'(4)) : r_addr;
         ram_wdata = wdata[r_gnt];
         if (ram_rdy && !RST) begin
            ack[r_gnt] = 1'b1;
            rdata      = ram_rdata;
         end
      end
   end

   // r_last resets to 3, so index 0 has first priority after reset.
   always_ff @(posedge CLK) begin
      // NOTE: state registers use non-blocking assignments. Every register
      // then updates from values taken before the clock edge.
      if (RST) begin
         r_state <= IDLE;
         r_last  <= 2'd3;
         r_gnt   <= 2'd0;
         r_wen   <= 1'b0;
         r_burst <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_any) begin
            r_gnt   <= w_winner;
            r_wen   <= wen[w_winner];
            r_burst <= burst[w_winner];
            r_addr  <= addr[w_winner];
         end
         if (w_done) begin
            r_last <= r_gnt;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed testbench for ram_arbiter. Inputs change on the falling edge.
// Outputs are sampled 1 ns later, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

   logic              CLK = 1'b0;
   logic              RST;
   logic [3:0]        req;
   logic [3:0]        wen;
   logic [3:0]        burst;
   logic [3:0][31:0]  addr;
   logic [3:0][31:0]  wdata;
   logic [3:0]        ack;
   logic [31:0]       rdata;
   logic              busy;
   logic [1:0]        gnt_id;
   logic              ram_ren;
   logic              ram_wen;
   logic [31:0]       ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;
   logic              ram_rdy;

   int n_pass  = 0;
   int n_total = 0;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req),
      .wen       (wen),
      .burst     (burst),
      .addr      (addr),
      .wdata     (wdata),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .gnt_id    (gnt_id),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_rdy   (ram_rdy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge CLK);
      RST = 1'b1; req = '0; wen = '0; burst = '0; ram_rdy = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; req = '0; wen = '0; burst = '0; addr = '0; wdata = '0;
      ram_rdata = '0; ram_rdy = 1'b0;
      apply_reset();
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (gnt_id !== 2'd0) $display("FAIL reset_gnt got %0d exp 0", gnt_id); else n_pass++;
      n_total++; if ({ram_ren, ram_wen} !== 2'b00) $display("FAIL reset_en got %b exp 00", {ram_ren, ram_wen}); else n_pass++;
      n_total++; if (ram_addr !== 32'h0) $display("FAIL reset_addr got %h exp 0", ram_addr); else n_pass++;
      n_total++; if (ram_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", ram_wdata); else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", ack); else n_pass++;
      n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
   endtask

   task automatic test_single_read();
      @(negedge CLK);
      req = 4'b0001; wen = '0; burst = '0; addr[0] = 32'h100; ram_rdy = 1'b0;
      #1;
      n_total++; if (ram_ren !== 1'b0) $display("FAIL rd_idle_ren got %b exp 0", ram_ren); else n_pass++;
      @(negedge CLK); #1;
      n_total++; if ({busy, ram_ren, ram_wen} !== 3'b110) $display("FAIL rd_w1_en got %b exp 110", {busy, ram_ren, ram_wen}); else n_pass++;
      n_total++; if (ram_addr !== 32'h100) $display("FAIL rd_w1_addr got %h exp 100", ram_addr); else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL rd_w1_noack got %b exp 0000", ack); else n_pass++;
      @(negedge CLK);
      ram_rdy = 1'b1; ram_rdata = 32'hDEADBEEF;
      #1;
      n_total++; if (ack !== 4'b0001) $display("FAIL rd_ack got %b exp 0001", ack); else n_pass++;
      n_total++; if (rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata got %h exp deadbeef", rdata); else n_pass++;
      @(negedge CLK);
      req = '0; ram_rdy = 1'b0;
      #1;
      n_total++; if ({busy, ram_ren, ack} !== 6'b0) $display("FAIL rd_done got %b exp 000000", {busy, ram_ren, ack}); else n_pass++;
   endtask

   task automatic test_burst_write();
      @(negedge CLK);
      req = 4'b1000; wen = 4'b1000; burst = 4'b1000; addr[3] = 32'h200; wdata[3] = 32'hA;
      @(negedge CLK);
      // Change the latched fields after the grant. They must have no effect.
      addr[3] = 32'h999; burst = '0; wen = '0; ram_rdy = 1'b1;
      #1;
      n_total++; if (gnt_id !== 2'd3) $display("FAIL bw_gnt got %0d exp 3", gnt_id); else n_pass++;
      n_total++; if ({ram_ren, ram_wen} !== 2'b01) $display("FAIL bw_w1_en got %b exp 01", {ram_ren, ram_wen}); else n_pass++;
      n_total++; if (ram_addr !== 32'h200) $display("FAIL bw_w1_addr got %h exp 200", ram_addr); else n_pass++;
      n_total++; if (ram_wdata !== 32'hA) $display("FAIL bw_w1_data got %h exp a", ram_wdata); else n_pass++;
      n_total++; if (ack !== 4'b1000) $display("FAIL bw_ack1 got %b exp 1000", ack); else n_pass++;
      @(negedge CLK);
      wdata[3] = 32'hB;
      #1;
      n_total++; if ({busy, ram_ren, ram_wen} !== 3'b101) $display("FAIL bw_w2_en got %b exp 101", {busy, ram_ren, ram_wen}); else n_pass++;
      n_total++; if (ram_addr !== 32'h204) $display("FAIL bw_w2_addr got %h exp 204", ram_addr); else n_pass++;
      n_total++; if (ram_wdata !== 32'hB) $display("FAIL bw_w2_data got %h exp b", ram_wdata); else n_pass++;
      n_total++; if (ack !== 4'b1000) $display("FAIL bw_ack2 got %b exp 1000", ack); else n_pass++;
      @(negedge CLK);
      req = '0; ram_rdy = 1'b0;
      #1;
      n_total++; if ({busy, ram_wen} !== 2'b00) $display("FAIL bw_done got %b exp 00", {busy, ram_wen}); else n_pass++;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_ack;
      apply_reset();
      @(negedge CLK);
      req = 4'b1111; wen = '0; burst = '0; ram_rdy = 1'b1; ram_rdata = 32'h55;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK); #1;
         exp_ack = 4'b0001 << (k % 4);
         n_total++; if (gnt_id !== 2'(k % 4)) $display("FAIL rr_gnt%0d got %0d exp %0d", k, gnt_id, k % 4); else n_pass++;
         n_total++; if (ack !== exp_ack) $display("FAIL rr_ack%0d got %b exp %b", k, ack, exp_ack); else n_pass++;
         @(negedge CLK); #1;
         n_total++; if (busy !== 1'b0) $display("FAIL rr_gap%0d got busy %b exp 0", k, busy); else n_pass++;
      end
      req = '0; ram_rdy = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      @(negedge CLK);
      req = 4'b0010; wen = '0; burst = 4'b0010; addr[1] = 32'h300; ram_rdy = 1'b0;
      @(negedge CLK);
      ram_rdy = 1'b1;
      #1;
      n_total++; if (ack !== 4'b0010) $display("FAIL rst_ack1 got %b exp 0010", ack); else n_pass++;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      n_total++; if (ram_addr !== 32'h304) $display("FAIL rst_w2_addr got %h exp 304", ram_addr); else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL rst_noack got %b exp 0000", ack); else n_pass++;
      @(negedge CLK);
      RST = 1'b0; req = 4'b0011; burst = '0;
      #1;
      n_total++; if ({busy, ram_ren, ram_wen} !== 3'b000) $display("FAIL rst_idle got %b exp 000", {busy, ram_ren, ram_wen}); else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL rst_idle_ack got %b exp 0000", ack); else n_pass++;
      @(negedge CLK); #1;
      n_total++; if (gnt_id !== 2'd0) $display("FAIL rst_next_gnt got %0d exp 0", gnt_id); else n_pass++;
      n_total++; if (ack !== 4'b0001) $display("FAIL rst_next_ack got %b exp 0001", ack); else n_pass++;
      @(negedge CLK);
      req = '0; ram_rdy = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_end got busy %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_addr_wrap();
      @(negedge CLK);
      req = 4'b0010; wen = '0; burst = 4'b0010; addr[1] = 32'hFFFFFFFC;
      ram_rdy = 1'b1; ram_rdata = 32'h11;
      @(negedge CLK); #1;
      n_total++; if (ram_addr !== 32'hFFFFFFFC) $display("FAIL wrap_w1_addr got %h exp fffffffc", ram_addr); else n_pass++;
      @(negedge CLK);
      req = '0;
      #1;
      n_total++; if (ram_addr !== 32'h0) $display("FAIL wrap_w2_addr got %h exp 00000000", ram_addr); else n_pass++;
      n_total++; if (ack !== 4'b0010) $display("FAIL wrap_ack2 got %b exp 0010", ack); else n_pass++;
      @(negedge CLK);
      ram_rdy = 1'b0; burst = '0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL wrap_end got busy %b exp 0", busy); else n_pass++;
   endtask

   task automatic test_req_drop();
      int n_ack = 0;
      @(negedge CLK);
      req = 4'b0010; wen = '0; burst = 4'b0010; addr[1] = 32'h400; ram_rdy = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (c == 0) begin
            req = '0;
            burst = '0;
         end
         ram_rdy = (c == 5 || c == 11);
         #1;
         if (ack[1]) n_ack++;
         n_total++; if ({busy, ram_ren} !== 2'b11) $display("FAIL drop_busy c%0d got %b exp 11", c, {busy, ram_ren}); else n_pass++;
         if (c == 5) begin
            n_total++; if (ram_addr !== 32'h400) $display("FAIL drop_w1_addr got %h exp 400", ram_addr); else n_pass++;
         end
         if (c == 11) begin
            n_total++; if (ram_addr !== 32'h404) $display("FAIL drop_w2_addr got %h exp 404", ram_addr); else n_pass++;
         end
      end
      @(negedge CLK);
      ram_rdy = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL drop_end got busy %b exp 0", busy); else n_pass++;
      n_total++; if (n_ack !== 2) $display("FAIL drop_ack_count got %0d exp 2", n_ack); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst_write();
      test_fairness();
      test_reset_mid_burst();
      test_addr_wrap();
      test_req_drop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
